// File: rtl/hdmi_cfg_pkg.sv
// Shared types and the fixed transmitter register table for the HDMI
// configuration sequencer.
package hdmi_cfg_pkg;

  typedef enum logic [1:0] {
    WAIT_HPD,
    PWRUP,
    INIT,
    RUN
  } state_t;

  localparam int NUM_CMDS = 13;
  localparam int IDX_W    = 4;

  // Each entry is {register address, register data}.
  function automatic logic [15:0] init_rom(input logic [IDX_W-1:0] idx);
    logic [15:0] word;
    word = 16'h0000;
    case (idx)
      4'd0:    word = 16'h9803;
      4'd1:    word = 16'h9AE0;
      4'd2:    word = 16'h9C30;
      4'd3:    word = 16'h9D61;
      4'd4:    word = 16'hA2A4;
      4'd5:    word = 16'hA3A4;
      4'd6:    word = 16'hE0D0;
      4'd7:    word = 16'hF900;
      4'd8:    word = 16'h1500;
      4'd9:    word = 16'h1670;
      4'd10:   word = 16'h1846;
      4'd11:   word = 16'h4110;
      4'd12:   word = 16'hAF04;
      default: word = 16'h0000;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/hdmi_hpd_sync.sv
// Hot-plug detect conditioning: two-flop synchronizer followed by a debounce
// counter that only moves hpd_q after HPD_DEBOUNCE consecutive differing cycles.
module hdmi_hpd_sync #(
  parameter int HPD_DEBOUNCE = 65536
) (
  input  logic clk,
  input  logic reset_n,
  input  logic hpd,
  output logic hpd_q
);

  localparam int            CW       = (HPD_DEBOUNCE > 1) ? $clog2(HPD_DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HPD_DEBOUNCE - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // NOTE: sequential state is only ever updated with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= 2'b00;
      cnt   <= '0;
      hpd_q <= 1'b0;
    end else begin
      sync <= {sync[0], hpd};
      if (sync[1] == hpd_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        hpd_q <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hdmi_cfg_seq.sv
// HDMI transmitter configuration sequencer and I2C write-engine arbiter.
// Optional HPD monitoring is enabled by defining HDMI_CFG_HPD_EN.
module hdmi_cfg_seq
  import hdmi_cfg_pkg::*;
#(
  parameter logic [7:0] DEVICE       = 8'h72,
  parameter int         PWRUP_CYCLES = 200000,
  parameter int         HPD_DEBOUNCE = 65536
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hpd,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       i2c_valid,
  input  logic       i2c_ready,
  output logic [7:0] i2c_device,
  output logic [7:0] i2c_addr,
  output logic [7:0] i2c_data,
  output logic       cfg_done,
  output logic [7:0] init_cnt
);

  localparam int               PW         = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  localparam logic [PW-1:0]    PWRUP_LOAD = PW'(PWRUP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CMDS - 1);

  logic hpd_q;

`ifdef HDMI_CFG_HPD_EN
  hdmi_hpd_sync #(
    .HPD_DEBOUNCE(HPD_DEBOUNCE)
  ) u_hpd_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .hpd    (hpd),
    .hpd_q  (hpd_q)
  );
`else
  // Link is treated as permanently plugged; hpd and the debounce length are inert.
  logic unused_hpd;
  assign unused_hpd = hpd ^ (HPD_DEBOUNCE == 0);
  assign hpd_q      = 1'b1;
`endif

  state_t           state, state_nxt;
  logic [PW-1:0]    pwr_cnt, pwr_cnt_nxt;
  logic [IDX_W-1:0] cmd_idx, cmd_idx_nxt;
  logic             valid_nxt, done_nxt;
  logic [7:0]       addr_nxt, data_nxt, init_cnt_nxt, init_bump;
  logic             xfer, req_accept, link_lost;
  logic [IDX_W-1:0] idx_next;

  assign i2c_device = DEVICE;
  assign req_ready  = (state == RUN) && !i2c_valid && hpd_q;
  assign xfer       = i2c_valid && i2c_ready;
  assign req_accept = req_valid && req_ready;
  assign idx_next   = cmd_idx + 1'b1;

  // A pending command is never withdrawn, so unplug waits for its transfer.
  assign link_lost  = !hpd_q && ((state == INIT) || (state == RUN)) && (!i2c_valid || xfer);

`ifdef HDMI_CFG_HPD_EN
  assign init_bump = init_cnt + 8'd1;
`else
  assign init_bump = 8'd1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= WAIT_HPD;
      pwr_cnt   <= '0;
      cmd_idx   <= '0;
      i2c_valid <= 1'b0;
      i2c_addr  <= 8'h00;
      i2c_data  <= 8'h00;
      cfg_done  <= 1'b0;
      init_cnt  <= 8'h00;
    end else begin
      state     <= state_nxt;
      pwr_cnt   <= pwr_cnt_nxt;
      cmd_idx   <= cmd_idx_nxt;
      i2c_valid <= valid_nxt;
      i2c_addr  <= addr_nxt;
      i2c_data  <= data_nxt;
      cfg_done  <= done_nxt;
      init_cnt  <= init_cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a hold value first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt    = state;
    pwr_cnt_nxt  = pwr_cnt;
    cmd_idx_nxt  = cmd_idx;
    valid_nxt    = i2c_valid;
    addr_nxt     = i2c_addr;
    data_nxt     = i2c_data;
    done_nxt     = cfg_done;
    init_cnt_nxt = init_cnt;

    case (state)
      WAIT_HPD: begin
        if (hpd_q) begin
          state_nxt   = PWRUP;
          pwr_cnt_nxt = PWRUP_LOAD;
        end
      end
      PWRUP: begin
        if (!hpd_q) begin
          state_nxt = WAIT_HPD;
        end else if (pwr_cnt == '0) begin
          state_nxt              = INIT;
          cmd_idx_nxt            = '0;
          valid_nxt              = 1'b1;
          {addr_nxt, data_nxt}   = init_rom('0);
        end else begin
          pwr_cnt_nxt = pwr_cnt - 1'b1;
        end
      end
      INIT: begin
        if (xfer) begin
          if (cmd_idx == LAST_IDX) begin
            state_nxt    = RUN;
            valid_nxt    = 1'b0;
            done_nxt     = 1'b1;
            init_cnt_nxt = init_bump;
          end else begin
            cmd_idx_nxt          = idx_next;
            {addr_nxt, data_nxt} = init_rom(idx_next);
          end
        end
      end
      RUN: begin
        if (req_accept) begin
          valid_nxt = 1'b1;
          addr_nxt  = req_addr;
          data_nxt  = req_data;
        end else if (xfer) begin
          valid_nxt = 1'b0;
        end
      end
      default: state_nxt = WAIT_HPD;
    endcase

    if (link_lost) begin
      state_nxt   = WAIT_HPD;
      done_nxt    = 1'b0;
      valid_nxt   = 1'b0;
      cmd_idx_nxt = '0;
    end
  end

endmodule

// File: tb/tb_hdmi_cfg_seq.sv
// Directed bench for hdmi_cfg_seq; exercises the HPD-monitored build when
// HDMI_CFG_HPD_EN is defined and the fixed-link build otherwise.
module tb_hdmi_cfg_seq;

  localparam int PWRUP = 8;
  localparam int DEB   = 4;
`ifdef HDMI_CFG_HPD_EN
  localparam int FIRST_LAT = 2 + DEB + PWRUP + 1;
`else
  localparam int FIRST_LAT = PWRUP + 1;
`endif
  localparam logic [15:0] ROM_EXP [13] = '{
    16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4, 16'hA3A4, 16'hE0D0,
    16'hF900, 16'h1500, 16'h1670, 16'h1846, 16'h4110, 16'hAF04
  };

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       hpd = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_data = 8'h00;
  logic       i2c_valid;
  logic       i2c_ready = 1'b0;
  logic [7:0] i2c_device, i2c_addr, i2c_data, init_cnt;
  logic       cfg_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hdmi_cfg_seq #(
    .DEVICE      (8'h72),
    .PWRUP_CYCLES(PWRUP),
    .HPD_DEBOUNCE(DEB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .hpd       (hpd),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .i2c_valid (i2c_valid),
    .i2c_ready (i2c_ready),
    .i2c_device(i2c_device),
    .i2c_addr  (i2c_addr),
    .i2c_data  (i2c_data),
    .cfg_done  (cfg_done),
    .init_cnt  (init_cnt)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    assert (obs === req) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},  32'(i2c_valid),  0);
    check({tag, "_ready"},  32'(req_ready),  0);
    check({tag, "_addr"},   32'(i2c_addr),   0);
    check({tag, "_data"},   32'(i2c_data),   0);
    check({tag, "_done"},   32'(cfg_done),   0);
    check({tag, "_cnt"},    32'(init_cnt),   0);
    check({tag, "_device"}, 32'(i2c_device), 32'h72);
  endtask

  // Counts cycles from the current falling edge until i2c_valid rises.
  task automatic wait_valid(input string tag, input int exp_lat);
    int n = 0;
    while (!i2c_valid && n < 200) begin
      tick();
      n++;
    end
    check(tag, n, exp_lat);
  endtask

  // Expects entries first..first+count-1 offered back-to-back with i2c_ready high.
  task automatic stream(input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      check("init_valid", 32'(i2c_valid), 1);
      check("init_word", 32'({i2c_addr, i2c_data}), 32'(ROM_EXP[i]));
      tick();
    end
  endtask

  task automatic check_done(input int exp_cnt);
    check("done_flag",  32'(cfg_done),  1);
    check("done_valid", 32'(i2c_valid), 0);
    check("done_cnt",   32'(init_cnt),  exp_cnt);
    check("done_ready", 32'(req_ready), 1);
  endtask

  task automatic run_request();
    i2c_ready = 1'b0;
    check("req_ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_addr  = 8'h41;
    req_data  = 8'h50;
    tick();
    req_valid = 1'b0;
    req_addr  = 8'hFF;
    req_data  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      check("req_pend_valid", 32'(i2c_valid), 1);
      check("req_pend_word", 32'({i2c_addr, i2c_data}), 32'h4150);
      check("req_pend_ready", 32'(req_ready), 0);
      tick();
    end
    i2c_ready = 1'b1;
    tick();
    i2c_ready = 1'b0;
    check("req_xfer_valid", 32'(i2c_valid), 0);
    check("req_xfer_ready", 32'(req_ready), 1);
  endtask

  task automatic reset_mid_init();
    i2c_ready = 1'b1;
    wait_valid("rst_first_lat", FIRST_LAT);
    stream(0, 3);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    tick();
    tick();
    check_reset_outputs("rst_hold");
    reset_n = 1'b1;
    wait_valid("rst_again_lat", FIRST_LAT);
    stream(0, 13);
    check_done(1);
  endtask

  initial begin
    tick();
    tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;

`ifdef HDMI_CFG_HPD_EN
    // Short HPD glitch must never reach the sequencer.
    hpd = 1'b1;
    tick();
    tick();
    tick();
    hpd = 1'b0;
    for (int i = 0; i < 30; i++) begin
      check("glitch_valid", 32'(i2c_valid), 0);
      tick();
    end

    hpd       = 1'b1;
    i2c_ready = 1'b1;
    wait_valid("plug_lat", FIRST_LAT);
    stream(0, 13);
    check_done(1);

    run_request();

    // Unplug in RUN with nothing pending: leave on the cycle after hpd_q falls.
    hpd = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("unplug_ready_pre", 32'(req_ready), 1);
    tick();
    check("unplug_ready_drop", 32'(req_ready), 0);
    check("unplug_done_hold", 32'(cfg_done), 1);
    tick();
    check("unplug_done_clr", 32'(cfg_done), 0);

    hpd       = 1'b1;
    i2c_ready = 1'b1;
    wait_valid("replug1_lat", FIRST_LAT);
    stream(0, 5);
    check("held_word_first", 32'({i2c_addr, i2c_data}), 32'hA3A4);
    i2c_ready = 1'b0;
    hpd       = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("held_valid", 32'(i2c_valid), 1);
      check("held_word", 32'({i2c_addr, i2c_data}), 32'hA3A4);
    end
    i2c_ready = 1'b1;
    tick();
    check("held_xfer_valid", 32'(i2c_valid), 0);
    check("held_xfer_done", 32'(cfg_done), 0);
    for (int i = 0; i < 20; i++) begin
      check("unplugged_idle", 32'(i2c_valid), 0);
      tick();
    end

    hpd = 1'b1;
    wait_valid("replug2_lat", FIRST_LAT);
    stream(0, 13);
    check_done(2);

    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_run");
    tick();
    reset_n = 1'b1;
    reset_mid_init();
`else
    i2c_ready = 1'b1;
    wait_valid("boot_lat", FIRST_LAT);
    stream(0, 13);
    check_done(1);

    run_request();

    for (int i = 0; i < 20; i++) begin
      hpd = ~hpd;
      tick();
      check("hpd_ignored_done", 32'(cfg_done), 1);
      check("hpd_ignored_ready", 32'(req_ready), 1);
    end
    check("hpd_ignored_cnt", 32'(init_cnt), 1);

    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_run");
    tick();
    reset_n = 1'b1;
    reset_mid_init();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
